gmii_rx_frame_ctrl: RTL and testbench

//  Receive-side sequencer after the RGMII->GMII DDR capture, in the gmii_rxc domain.

---
 rtl/gmii_rx_frame_ctrl_if.sv | 25 ++
 rtl/gmii_rx_frame_ctrl.sv | 152 +++++++++++++++
 tb/tb_gmii_rx_frame_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/gmii_rx_frame_ctrl_if.sv
// gmii_rx_frame_ctrl_if: GMII receive byte input and delimited frame output stream
//  gmii_rxdv/gmii_rxd              : GMII receive data valid and byte (into the controller)
//  out_valid/out_data              : one frame byte per valid cycle, no backpressure
//  out_sof/out_eof                 : first/last byte markers
//  out_len/out_status              : frame length and {addr_miss, giant, runt}, valid with out_eof
interface gmii_rx_frame_ctrl_if #(
    parameter int LEN_W = 11
);
    logic             gmii_rxdv;
    logic [7:0]       gmii_rxd;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_sof;
    logic             out_eof;
    logic [LEN_W-1:0] out_len;
    logic [2:0]       out_status;
    modport master (
        input  gmii_rxdv, gmii_rxd,
        output out_valid, out_data, out_sof, out_eof, out_len, out_status
    );
    modport slave (
        output gmii_rxdv, gmii_rxd,
        input  out_valid, out_data, out_sof, out_eof, out_len, out_status
    );
endinterface

// File: rtl/gmii_rx_frame_ctrl.sv
// gmii_rx_frame_ctrl: strips preamble/SFD from GMII receive bytes and delimits frames with length/status
//  gmii_rxc      : receive clock
//  reset         : synchronous active-high reset
//  bus           : GMII input and frame output stream (master side)
//  frame_ok_cnt  : saturating count of frames ended with status 0
//  frame_err_cnt : saturating count of errored frames plus discarded bursts
module gmii_rx_frame_ctrl #(
    parameter logic [47:0] LOCAL_MAC    = 48'h000A3501FEC0,
    parameter bit          FILTER_EN    = 1'b1,
    parameter int          MIN_PREAMBLE = 2,
    parameter int          MIN_LEN      = 64,
    parameter int          MAX_LEN      = 1518,
    parameter int          LEN_W        = 11
) (
    input  logic                 gmii_rxc,
    input  logic                 reset,
    gmii_rx_frame_ctrl_if.master bus,
    output logic [15:0]          frame_ok_cnt,
    output logic [15:0]          frame_err_cnt
);
    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DISCARD} state_t;
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] DA_L  = LEN_W'(6);
    localparam logic [2:0]       MIN_P = 3'(MIN_PREAMBLE);
    state_t           state_q, state_d;
    logic [2:0]       pcnt_q, pcnt_d;
    logic [LEN_W-1:0] bcnt_q, bcnt_d;
    logic [7:0]       hold_q, hold_d;
    logic             mac_ok_q, mac_ok_d;
    logic             bc_ok_q, bc_ok_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_sof_q, out_sof_d;
    logic             out_eof_q, out_eof_d;
    logic [LEN_W-1:0] out_len_q, out_len_d;
    logic [2:0]       out_status_q, out_status_d;
    logic [15:0]      frame_ok_cnt_q, frame_ok_cnt_d;
    logic [15:0]      frame_err_cnt_q, frame_err_cnt_d;
    logic             disc_inc, giant, runt, miss;
    logic [7:0]       mac_byte;
    logic [16:0]      ok_sum, err_sum;
    always_comb begin
        state_d  = state_q;
        pcnt_d   = pcnt_q;
        bcnt_d   = bcnt_q;
        hold_d   = hold_q;
        mac_ok_d = mac_ok_q;
        bc_ok_d  = bc_ok_q;
        out_valid_d = 1'b0;
        out_eof_d   = 1'b0;
        giant    = 1'b0;
        disc_inc = 1'b0;
        // DA byte n (0-based) of LOCAL_MAC, MSB first
        mac_byte = 8'(LOCAL_MAC >> {3'd5 - bcnt_q[2:0], 3'b000});
        runt     = bcnt_q < MIN_L;
        miss     = FILTER_EN && (bcnt_q < DA_L || !(mac_ok_q || bc_ok_q));
        case (state_q)
            IDLE: begin
                if (bus.gmii_rxdv) begin
                    state_d  = bus.gmii_rxd == 8'h55 ? PREAMBLE : DISCARD;
                    pcnt_d   = 3'd1;
                    disc_inc = bus.gmii_rxd != 8'h55;
                end
            end
            PREAMBLE: begin
                if (!bus.gmii_rxdv) begin
                    state_d = IDLE;
                end else if (bus.gmii_rxd == 8'h55) begin
                    pcnt_d = pcnt_q == 3'd7 ? 3'd7 : pcnt_q + 3'd1;
                end else if (bus.gmii_rxd == 8'hD5 && pcnt_q >= MIN_P) begin
                    state_d  = DATA;
                    bcnt_d   = '0;
                    mac_ok_d = 1'b1;
                    bc_ok_d  = 1'b1;
                end else begin
                    state_d  = DISCARD;
                    disc_inc = 1'b1;
                end
            end
            DATA: begin
                // the held byte goes out when its successor arrives or rxdv falls
                out_valid_d = bcnt_q != '0;
                if (!bus.gmii_rxdv) begin
                    state_d   = IDLE;
                    out_eof_d = bcnt_q != '0;
                end else if (bcnt_q == MAX_L) begin
                    // giant: close the frame on byte MAX_LEN; the DISCARD entry is not counted again
                    state_d   = DISCARD;
                    out_eof_d = 1'b1;
                    giant     = 1'b1;
                end else begin
                    hold_d   = bus.gmii_rxd;
                    bcnt_d   = bcnt_q + 1'b1;
                    mac_ok_d = mac_ok_q && (bcnt_q >= DA_L || bus.gmii_rxd == mac_byte);
                    bc_ok_d  = bc_ok_q && (bcnt_q >= DA_L || bus.gmii_rxd == 8'hFF);
                end
            end
            default: state_d = bus.gmii_rxdv ? DISCARD : IDLE;
        endcase
        out_data_d   = out_valid_d ? hold_q : 8'h00;
        out_sof_d    = out_valid_d && bcnt_q == LEN_W'(1);
        out_len_d    = out_eof_d ? bcnt_q : '0;
        out_status_d = out_eof_d ? {miss, giant, runt} : 3'b000;
        // counters follow the registered eof, so they move one cycle after out_eof
        ok_sum  = {1'b0, frame_ok_cnt_q} + {16'b0, out_eof_q && out_status_q == 3'b000};
        err_sum = {1'b0, frame_err_cnt_q} + {16'b0, out_eof_q && out_status_q != 3'b000} + {16'b0, disc_inc};
        frame_ok_cnt_d  = ok_sum[16] ? 16'hFFFF : ok_sum[15:0];
        frame_err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
    always_ff @(posedge gmii_rxc) begin
        if (reset) begin
            state_q         <= IDLE;
            pcnt_q          <= '0;
            bcnt_q          <= '0;
            hold_q          <= '0;
            mac_ok_q        <= 1'b0;
            bc_ok_q         <= 1'b0;
            out_valid_q     <= 1'b0;
            out_data_q      <= '0;
            out_sof_q       <= 1'b0;
            out_eof_q       <= 1'b0;
            out_len_q       <= '0;
            out_status_q    <= '0;
            frame_ok_cnt_q  <= '0;
            frame_err_cnt_q <= '0;
        end else begin
            state_q         <= state_d;
            pcnt_q          <= pcnt_d;
            bcnt_q          <= bcnt_d;
            hold_q          <= hold_d;
            mac_ok_q        <= mac_ok_d;
            bc_ok_q         <= bc_ok_d;
            out_valid_q     <= out_valid_d;
            out_data_q      <= out_data_d;
            out_sof_q       <= out_sof_d;
            out_eof_q       <= out_eof_d;
            out_len_q       <= out_len_d;
            out_status_q    <= out_status_d;
            frame_ok_cnt_q  <= frame_ok_cnt_d;
            frame_err_cnt_q <= frame_err_cnt_d;
        end
    end
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_sof    = out_sof_q;
    assign bus.out_eof    = out_eof_q;
    assign bus.out_len    = out_len_q;
    assign bus.out_status = out_status_q;
    assign frame_ok_cnt   = frame_ok_cnt_q;
    assign frame_err_cnt  = frame_err_cnt_q;
endmodule

// File: tb/tb_gmii_rx_frame_ctrl.sv
// tb_gmii_rx_frame_ctrl: directed and randomized bursts checked against a burst-level frame model
module tb_gmii_rx_frame_ctrl;
    localparam logic [47:0] MAC   = 48'h000A3501FEC0;
    localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;
    localparam int MIN_P = 2;
    localparam int MIN_L = 64;
    localparam int MAX_L = 1518;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int sof_cyc = 0;
    logic [15:0] ok_cnt, err_cnt, ok_nf, err_nf;
    logic [7:0] got_data[$], exp_data[$];
    int got_sof[$], exp_sof[$], got_eof[$], exp_eof[$], got_len[$], exp_len[$];
    logic [2:0] got_st[$], exp_st[$], got_nf[$], exp_nf[$];
    int pd = 0, ps = 0, pe = 0, pn = 0;
    int exp_ok = 0, exp_err = 0, exp_ok_nf = 0, exp_err_nf = 0;
    gmii_rx_frame_ctrl_if #(.LEN_W(11)) bus ();
    gmii_rx_frame_ctrl_if #(.LEN_W(11)) bus_nf ();
    gmii_rx_frame_ctrl dut (
        .gmii_rxc(clk), .reset(rst), .bus(bus.master),
        .frame_ok_cnt(ok_cnt), .frame_err_cnt(err_cnt)
    );
    gmii_rx_frame_ctrl #(.FILTER_EN(1'b0)) dut_nf (
        .gmii_rxc(clk), .reset(rst), .bus(bus_nf.master),
        .frame_ok_cnt(ok_nf), .frame_err_cnt(err_nf)
    );
    assign bus_nf.gmii_rxdv = bus.gmii_rxdv;
    assign bus_nf.gmii_rxd  = bus.gmii_rxd;
    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bus.out_valid) begin
            if (bus.out_sof) begin
                got_sof.push_back(got_data.size());
                sof_cyc = cyc;
            end
            got_data.push_back(bus.out_data);
            if (bus.out_eof) begin
                got_eof.push_back(got_data.size());
                got_len.push_back(int'(bus.out_len));
                got_st.push_back(bus.out_status);
            end
        end
        if (bus_nf.out_valid && bus_nf.out_eof) got_nf.push_back(bus_nf.out_status);
    end
    task automatic chk(input string tag, input integer got, input integer exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic int sat(input int v);
        return v > 65535 ? 65535 : v;
    endfunction
    task automatic mk(output logic [7:0] q[$], input int npre, input logic [47:0] da, input int len);
        q = {};
        repeat (npre) q.push_back(8'h55);
        q.push_back(8'hD5);
        for (int i = 0; i < len; i++) q.push_back(i < 6 ? da[47-8*i -: 8] : 8'($urandom));
    endtask
    task automatic model(input logic [7:0] b[$]);
        int i = 0;
        int n, len;
        logic [47:0] da = '0;
        logic [2:0] st, st_nf;
        while (i < b.size() && b[i] == 8'h55) i++;
        if (i == b.size()) return;
        if (i == 0 || b[i] != 8'hD5 || i < MIN_P) begin
            exp_err = sat(exp_err + 1);
            exp_err_nf = sat(exp_err_nf + 1);
            return;
        end
        n = b.size() - i - 1;
        if (n == 0) return;
        len = n > MAX_L ? MAX_L : n;
        for (int k = 0; k < 6 && k < len; k++) da = {da[39:0], b[i+1+k]};
        st_nf = {1'b0, n > MAX_L, len < MIN_L};
        st = st_nf | {len < 6 || (da != MAC && da != BCAST), 2'b00};
        exp_sof.push_back(exp_data.size());
        for (int k = 0; k < len; k++) exp_data.push_back(b[i+1+k]);
        exp_eof.push_back(exp_data.size());
        exp_len.push_back(len);
        exp_st.push_back(st);
        exp_nf.push_back(st_nf);
        if (st == 3'b000) exp_ok = sat(exp_ok + 1); else exp_err = sat(exp_err + 1);
        if (st_nf == 3'b000) exp_ok_nf = sat(exp_ok_nf + 1); else exp_err_nf = sat(exp_err_nf + 1);
    endtask
    task automatic send(input logic [7:0] b[$], input int gap);
        for (int i = 0; i < b.size(); i++) begin
            bus.gmii_rxdv = 1'b1;
            bus.gmii_rxd  = b[i];
            @(negedge clk);
        end
        bus.gmii_rxdv = 1'b0;
        bus.gmii_rxd  = 8'($urandom);
        repeat (gap) @(negedge clk);
    endtask
    task automatic check_step(input string tag);
        int bad = 0;
        chk({tag, "/nbytes"}, got_data.size(), exp_data.size());
        for (int i = pd; i < exp_data.size() && i < got_data.size(); i++) if (got_data[i] !== exp_data[i]) bad++;
        chk({tag, "/data"}, bad, 0);
        chk({tag, "/nsof"}, got_sof.size(), exp_sof.size());
        for (int i = ps; i < exp_sof.size() && i < got_sof.size(); i++) chk({tag, "/sof_pos"}, got_sof[i], exp_sof[i]);
        chk({tag, "/neof"}, got_eof.size(), exp_eof.size());
        for (int i = pe; i < exp_eof.size() && i < got_eof.size(); i++) begin
            chk({tag, "/eof_pos"}, got_eof[i], exp_eof[i]);
            chk({tag, "/len"}, got_len[i], exp_len[i]);
            chk({tag, "/status"}, 32'(got_st[i]), 32'(exp_st[i]));
        end
        chk({tag, "/nf_neof"}, got_nf.size(), exp_nf.size());
        for (int i = pn; i < exp_nf.size() && i < got_nf.size(); i++) chk({tag, "/nf_status"}, 32'(got_nf[i]), 32'(exp_nf[i]));
        chk({tag, "/ok_cnt"}, 32'(ok_cnt), exp_ok);
        chk({tag, "/err_cnt"}, 32'(err_cnt), exp_err);
        chk({tag, "/nf_ok_cnt"}, 32'(ok_nf), exp_ok_nf);
        chk({tag, "/nf_err_cnt"}, 32'(err_nf), exp_err_nf);
        pd = exp_data.size();
        ps = exp_sof.size();
        pe = exp_eof.size();
        pn = exp_nf.size();
    endtask
    task automatic run(input string tag, input logic [7:0] q[$]);
        model(q);
        send(q, 3);
        check_step(tag);
    endtask
    initial begin
        logic [7:0] q[$], q2[$], rest[$];
        int c0, pos;
        bus.gmii_rxdv = 1'b0;
        bus.gmii_rxd  = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_out", 32'({bus.out_valid, bus.out_sof, bus.out_eof, bus.out_data, bus.out_len, bus.out_status}), 0);
        chk("reset_cnt", 32'({ok_cnt, err_cnt}), 0);
        rst = 1'b0;
        @(negedge clk);
        // good 64-byte frame to own MAC, 7 preamble bytes
        mk(q, 7, MAC, 64);
        c0 = cyc;
        run("good64", q);
        chk("latency", sof_cyc - c0, 10);
        chk("good64_len_lit", got_len[got_len.size()-1], 64);
        // broadcast runt
        mk(q, 7, BCAST, 60);
        run("bcast60", q);
        // foreign DA: addr_miss only with filtering enabled
        mk(q, 7, 48'h020000000001, 100);
        run("miss100", q);
        // giant, then exact-MAX and MAX+1 boundaries, then a normal frame
        mk(q, 7, MAC, 1600);
        run("giant1600", q);
        mk(q, 7, MAC, 64);
        run("after_giant", q);
        mk(q, 7, MAC, MAX_L);
        run("max_len", q);
        mk(q, 2, BCAST, MAX_L + 1);
        run("max_plus1", q);
        // preamble errors and short frames
        mk(q, 1, MAC, 64);
        run("short_pre", q);
        q = '{8'h55, 8'h55, 8'h55};
        run("pre_drop", q);
        q = '{8'h12, 8'h55, 8'hD5, 8'h00};
        run("no_pre", q);
        mk(q, 2, MAC, 1);
        run("one_byte", q);
        mk(q, 3, MAC, 5);
        run("five_byte", q);
        // rxdv rising in the cycle right after eof
        mk(q, 7, MAC, 70);
        mk(q2, 7, BCAST, 66);
        model(q);
        model(q2);
        send(q, 1);
        send(q2, 3);
        check_step("b2b");
        // randomized bursts
        for (int r = 0; r < 12; r++) begin
            int sel = $urandom_range(0, 2);
            mk(q, $urandom_range(0, 8), sel == 0 ? MAC : sel == 1 ? BCAST : {$urandom, 16'($urandom)}, $urandom_range(1, 90));
            if (r % 4 == 3) q[$urandom_range(0, 2)] = 8'($urandom);
            run("rand", q);
        end
        // reset on payload byte 30: 29 bytes already out, no eof, counters cleared
        mk(q, 7, MAC, 100);
        pos = 8 + 30;
        for (int i = 0; i < q.size(); i++) begin
            bus.gmii_rxdv = 1'b1;
            bus.gmii_rxd  = q[i];
            rst = (i == pos);
            @(negedge clk);
            if (i == pos) begin
                chk("midrst_out", 32'({bus.out_valid, bus.out_sof, bus.out_eof, bus.out_data, bus.out_len, bus.out_status}), 0);
                chk("midrst_cnt", 32'({ok_cnt, err_cnt, ok_nf, err_nf}), 0);
            end
        end
        rst = 1'b0;
        bus.gmii_rxdv = 1'b0;
        repeat (3) @(negedge clk);
        exp_sof.push_back(exp_data.size());
        for (int k = 0; k < 29; k++) exp_data.push_back(q[8+k]);
        exp_ok = 0;
        exp_err = 0;
        exp_ok_nf = 0;
        exp_err_nf = 0;
        rest = q[pos+1:$];
        model(rest);
        check_step("midrst");
        mk(q, 7, MAC, 64);
        run("after_rst", q);
        chk("after_rst_ok1", 32'(ok_cnt), 1);
        // ok counter saturation
        force dut.frame_ok_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_ok_cnt_q;
        exp_ok = 65535;
        mk(q, 7, MAC, 64);
        run("sat", q);
        chk("sat_lit", 32'(ok_cnt), 32'hFFFF);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
